// File: rtl/response_encoder.sv
// -----------------------------------------------------------------------------
// response_encoder
//
// Transmit side of the host command link. On an accepted start request the
// command result (command, 15-bit address, 32-bit data, 2-bit error code) is
// latched into a frame register and serialized as a fixed-length sequence of
// 8N1 UART bytes. Byte order on the line:
//   0: command
//   1: {1'b0, address[14:8]}
//   2: address[7:0]
//   3..6: data, MSB byte first
//   7: {6'b0, error}
//   8: XOR of bytes 0..7 (only when RESPONSE_CHECKSUM_EN is defined)
//
// Configuration macro: RESPONSE_CHECKSUM_EN
//   defined   -> 9-byte frame with trailing XOR checksum byte
//   undefined -> 8-byte frame, no checksum logic
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (minimum 2)
//
// Ports:
//   clock         system clock
//   reset_n       synchronous, active-low reset
//   i_start       request to send one frame (sampled only while idle)
//   i_command     command byte to echo
//   i_address     15-bit address to echo
//   i_data        32-bit data word
//   i_error       2-bit error code
//   o_serial      UART line, idle high
//   o_busy        frame in progress
//   o_done        one-cycle pulse in the first cycle after the last stop bit
//   o_byte_index  index of the byte currently on the line (debug)
//   state         FSM state encoding (debug)
// -----------------------------------------------------------------------------
module response_encoder #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic [7:0]  i_command,
    input  logic [14:0] i_address,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_error,
    output logic        o_serial,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_byte_index,
    output logic [2:0]  state
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef RESPONSE_CHECKSUM_EN
    localparam int NUM_BYTES = 9;
`else
    localparam int NUM_BYTES = 8;
`endif

    localparam int FRAME_W = NUM_BYTES * 8;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [3:0]       LAST_BYTE = 4'(NUM_BYTES - 1);

    // NEXT is a reserved encoding: the byte-advance bookkeeping happens in the
    // last STOP cycle, so the FSM never sits in it.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        NEXT  = 3'd4
    } state_t;

`ifdef RESPONSE_CHECKSUM_EN
    // XOR of the eight payload bytes.
    function automatic logic [7:0] xor_bytes(input logic [63:0] payload);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ payload[8*i +: 8];
        end
        return acc;
    endfunction
`endif

    // Assemble the frame with byte 0 in the least significant position.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [7:0]  cmd,
        input logic [14:0] addr,
        input logic [31:0] data,
        input logic [1:0]  err
    );
        logic [63:0] payload;
        payload = {{6'b000000, err},
                   data[7:0], data[15:8], data[23:16], data[31:24],
                   addr[7:0],
                   {1'b0, addr[14:8]},
                   cmd};
`ifdef RESPONSE_CHECKSUM_EN
        return {xor_bytes(payload), payload};
`else
        return payload;
`endif
    endfunction

    // Pick one byte out of the frame register by index.
    function automatic logic [7:0] sel_byte(
        input logic [FRAME_W-1:0] frame,
        input logic [3:0]         idx
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = frame[7:0];
            4'd1:    b = frame[15:8];
            4'd2:    b = frame[23:16];
            4'd3:    b = frame[31:24];
            4'd4:    b = frame[39:32];
            4'd5:    b = frame[47:40];
            4'd6:    b = frame[55:48];
            4'd7:    b = frame[63:56];
`ifdef RESPONSE_CHECKSUM_EN
            4'd8:    b = frame[71:64];
`endif
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    state_t               state_r,    state_s;
    logic [CNT_W-1:0]     clk_cnt_r,  clk_cnt_s;
    logic [2:0]           bit_cnt_r,  bit_cnt_s;
    logic [3:0]           byte_idx_r, byte_idx_s;
    logic [7:0]           shift_r,    shift_s;
    logic [FRAME_W-1:0]   frame_r,    frame_s;
    logic                 serial_r,   serial_s;
    logic                 busy_r,     busy_s;
    logic                 done_r,     done_s;

    // Next-state and next-output computation for the byte sequencer.
    always_comb begin
        state_s    = state_r;
        clk_cnt_s  = clk_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        byte_idx_s = byte_idx_r;
        shift_s    = shift_r;
        frame_s    = frame_r;
        serial_s   = serial_r;
        busy_s     = busy_r;
        done_s     = 1'b0;

        case (state_r)
            IDLE: begin
                serial_s   = 1'b1;
                busy_s     = 1'b0;
                byte_idx_s = 4'd0;
                clk_cnt_s  = CNT_ZERO;
                bit_cnt_s  = 3'd0;
                if (i_start) begin
                    // Start bit goes out in the very next cycle.
                    frame_s  = build_frame(i_command, i_address, i_data, i_error);
                    shift_s  = i_command;
                    state_s  = START;
                    serial_s = 1'b0;
                    busy_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end

            START: begin
                if (clk_cnt_r == CNT_LAST) begin
                    clk_cnt_s = CNT_ZERO;
                    bit_cnt_s = 3'd0;
                    state_s   = DATA;
                    serial_s  = shift_r[0];
                    shift_s   = {1'b0, shift_r[7:1]};
                end else begin
                    clk_cnt_s = clk_cnt_r + CNT_ONE;
                end
            end

            DATA: begin
                if (clk_cnt_r == CNT_LAST) begin
                    clk_cnt_s = CNT_ZERO;
                    if (bit_cnt_r == 3'd7) begin
                        bit_cnt_s = 3'd0;
                        state_s   = STOP;
                        serial_s  = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        serial_s  = shift_r[0];
                        shift_s   = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CNT_ONE;
                end
            end

            STOP: begin
                if (clk_cnt_r == CNT_LAST) begin
                    clk_cnt_s = CNT_ZERO;
                    if (byte_idx_r == LAST_BYTE) begin
                        state_s    = IDLE;
                        serial_s   = 1'b1;
                        busy_s     = 1'b0;
                        done_s     = 1'b1;
                        byte_idx_s = 4'd0;
                    end else begin
                        // Advance to the next byte with no idle gap.
                        byte_idx_s = byte_idx_r + 4'd1;
                        shift_s    = sel_byte(frame_r, byte_idx_r + 4'd1);
                        state_s    = START;
                        serial_s   = 1'b0;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_s    = IDLE;
                clk_cnt_s  = CNT_ZERO;
                bit_cnt_s  = 3'd0;
                byte_idx_s = 4'd0;
                serial_s   = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            clk_cnt_r  <= CNT_ZERO;
            bit_cnt_r  <= 3'd0;
            byte_idx_r <= 4'd0;
            shift_r    <= 8'h00;
            frame_r    <= {FRAME_W{1'b0}};
            serial_r   <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            clk_cnt_r  <= clk_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            byte_idx_r <= byte_idx_s;
            shift_r    <= shift_s;
            frame_r    <= frame_s;
            serial_r   <= serial_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign o_serial     = serial_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_byte_index = byte_idx_r;
    assign state        = state_r;

endmodule

// File: tb/tb_response_encoder.sv
// -----------------------------------------------------------------------------
// tb_response_encoder
//
// Directed stimulus for response_encoder with CLKS_PER_BIT = 4. Expected frame
// bytes are pushed into a queue when a frame is started; an independent line
// monitor decodes 8N1 bytes from o_serial and compares each against the queue.
// -----------------------------------------------------------------------------
module tb_response_encoder;

    localparam int CPB = 4;
`ifdef RESPONSE_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = NB * BYTE_CYC;

    logic        clock;
    logic        reset_n;
    logic        i_start;
    logic [7:0]  i_command;
    logic [14:0] i_address;
    logic [31:0] i_data;
    logic [1:0]  i_error;
    logic        o_serial;
    logic        o_busy;
    logic        o_done;
    logic [3:0]  o_byte_index;
    logic [2:0]  state;

    int checks;
    int errors;
    int done_cnt;
    logic [7:0] exp_q[$];

    response_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_start      (i_start),
        .i_command    (i_command),
        .i_address    (i_address),
        .i_data       (i_data),
        .i_error      (i_error),
        .o_serial     (o_serial),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_byte_index (o_byte_index),
        .state        (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Count o_done pulses on the edge that ends each cycle.
    initial begin
        done_cnt = 0;
        forever begin
            @(posedge clock);
            if (o_done === 1'b1) done_cnt++;
        end
    end

    // Line monitor: decode 8N1 bytes mid-bit and compare against the queue.
    initial begin
        int cyc;
        int k;
        logic [7:0] rx;
        logic [7:0] expb;
        cyc = -1;
        rx  = 8'h00;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                cyc = -1;
            end else if (cyc < 0) begin
                if (o_serial === 1'b0) cyc = 0;
            end else begin
                cyc++;
            end
            if (reset_n && cyc >= 0 && (cyc % CPB) == CPB / 2) begin
                k = cyc / CPB;
                if (k == 0) begin
                    chk("start_bit", o_serial, 1'b0);
                end else if (k <= 8) begin
                    rx[k-1] = o_serial;
                end else begin
                    chk("stop_bit", o_serial, 1'b1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", rx, 9'h100);
                    end else begin
                        expb = exp_q.pop_front();
                        chk("frame_byte", rx, expb);
                    end
                end
            end
            if (cyc == BYTE_CYC - 1) cyc = -1;
        end
    end

    // Issue a frame at a negedge; expected bytes given with byte 0 in the MSBs.
    task automatic start_frame(input logic [7:0] cmd, input logic [14:0] addr,
                               input logic [31:0] data, input logic [1:0] err,
                               input logic [63:0] exp_bytes);
        logic [7:0] cks;
        cks = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(exp_bytes[8*i +: 8]);
            cks = cks ^ exp_bytes[8*i +: 8];
        end
`ifdef RESPONSE_CHECKSUM_EN
        exp_q.push_back(cks);
`endif
        i_command = cmd;
        i_address = addr;
        i_data    = data;
        i_error   = err;
        i_start   = 1'b1;
        @(posedge clock);
        #1;
        i_start   = 1'b0;
        // Disturb the inputs: the frame must come from the latched copy.
        i_command = ~cmd;
        i_address = ~addr;
        i_data    = ~data;
        i_error   = ~err;
        @(negedge clock);
        chk("cycle1_serial", o_serial, 1'b0);
        chk("cycle1_busy", o_busy, 1'b1);
        chk("cycle1_state", state, 3'd1);
        chk("cycle1_byte_index", o_byte_index, 4'd0);
    endtask

    // Follow a frame from cycle 1 to o_done; optionally inject a start request.
    task automatic wait_done(input int inject_at);
        int n;
        bit got;
        bit busy_ok;
        n       = 1;
        got     = 1'b0;
        busy_ok = 1'b1;
        while (n < FRAME_CYC + 50) begin
            @(negedge clock);
            n++;
            if (o_done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (o_busy !== 1'b1) busy_ok = 1'b0;
            if (((n - 1) % BYTE_CYC) == 0 && n <= FRAME_CYC)
                chk("byte_index", o_byte_index, 4'((n - 1) / BYTE_CYC));
            if (n == inject_at) begin
                i_start   = 1'b1;
                i_command = 8'hEE;
                i_data    = 32'h5555_5555;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        chk("done_seen", got, 1'b1);
        chk("done_cycle", n, FRAME_CYC + 1);
        chk("busy_during_frame", busy_ok, 1'b1);
        chk("busy_at_done", o_busy, 1'b0);
        chk("state_at_done", state, 3'd0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        int n;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        i_start   = 1'b0;
        i_command = 8'h00;
        i_address = 15'h0000;
        i_data    = 32'h0000_0000;
        i_error   = 2'b00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_serial", o_serial, 1'b1);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_done", o_done, 1'b0);
        chk("reset_byte_index", o_byte_index, 4'd0);
        chk("reset_state", state, 3'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Basic frame.
        start_frame(8'h10, 15'h00AB, 32'h00FF_12CD, 2'd0, 64'h10_00_AB_00_FF_12_CD_00);
        wait_done(0);
        repeat (3) @(negedge clock);

        // Address high bits and error code.
        start_frame(8'hA5, 15'h7FFF, 32'hDEAD_BEEF, 2'd3, 64'hA5_7F_FF_DE_AD_BE_EF_03);
        wait_done(0);
        repeat (3) @(negedge clock);

        // Start request while busy is ignored.
        d0 = done_cnt;
        start_frame(8'h5A, 15'h0102, 32'hCAFE_F00D, 2'd1, 64'h5A_01_02_CA_FE_F0_0D_01);
        wait_done(30);
        repeat (FRAME_CYC + 80) @(negedge clock);
        chk("single_done", done_cnt - d0, 1);
        chk("no_extra_frame", o_busy, 1'b0);

        // Back-to-back: next request in the o_done cycle.
        start_frame(8'h3C, 15'h1234, 32'h0102_0304, 2'd1, 64'h3C_12_34_01_02_03_04_01);
        wait_done(0);
        start_frame(8'hC3, 15'h4321, 32'h89AB_CDEF, 2'd2, 64'hC3_43_21_89_AB_CD_EF_02);
        wait_done(0);
        repeat (3) @(negedge clock);

        // Reset in the middle of a frame.
        d0 = done_cnt;
        start_frame(8'h10, 15'h00AB, 32'h00FF_12CD, 2'd0, 64'h10_00_AB_00_FF_12_CD_00);
        n = 1;
        while (n < 40) begin
            @(negedge clock);
            n++;
        end
        reset_n = 1'b0;
        @(negedge clock);
        chk("midreset_serial", o_serial, 1'b1);
        chk("midreset_busy", o_busy, 1'b0);
        chk("midreset_state", state, 3'd0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        repeat (FRAME_CYC) @(negedge clock);
        chk("midreset_no_done", done_cnt - d0, 0);
        chk("midreset_idle_line", o_serial, 1'b1);

        // Full frame after the abandoned one.
        start_frame(8'h77, 15'h0F0F, 32'h1122_3344, 2'd0, 64'h77_0F_0F_11_22_33_44_00);
        wait_done(0);
        repeat (5) @(negedge clock);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
